// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Contents:
//   DIGIT_W            width of a digit magnitude
//   DEFAULT_NUM_DIGITS default number of scanned digits
//   digit_t            stored digit record {sinal, diff}
//   slot_phase_e       BLANK/SHOW phase of the current digit slot
//   DIGIT_ON/DIGIT_OFF logical digit select levels, before polarity is applied
package display_pkg;

    localparam int unsigned DIGIT_W            = 4;
    localparam int unsigned DEFAULT_NUM_DIGITS = 4;

    typedef struct packed {
        logic               sinal;
        logic [DIGIT_W-1:0] diff;
    } digit_t;

    typedef enum logic {
        PhBlank,
        PhShow
    } slot_phase_e;

    localparam logic DIGIT_ON  = 1'b1;
    localparam logic DIGIT_OFF = 1'b0;

endpackage

// File: rtl/display_slot_timer.sv
// Scan timing for the display: counts cycles within a digit slot, steps the digit index
// and flags the slot phase and the frame boundary.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   en         1: counters advance; 0: counters hold
//   idx_next   digit index for the next cycle
//   phase_next BLANK/SHOW phase for the next cycle
//   frame_tick high on the last cycle of a frame while enabled
module display_slot_timer
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [IDX_W-1:0] idx_next,
    output slot_phase_e      phase_next,
    output logic             frame_tick
);

    localparam int unsigned      CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_slot, last_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

    assign last_slot  = (slot_cnt_q == LAST_SLOT);
    assign last_idx   = (idx_q == LAST_IDX);
    assign frame_tick = en & last_slot & last_idx;

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        idx_d      = idx_q;
        if (en) begin
            if (last_slot) begin
                slot_cnt_d = '0;
                idx_d      = last_idx ? '0 : idx_q + IDX_W'(1);
            end else begin
                slot_cnt_d = slot_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-cycle view lets the parent register its outputs aligned with the counters.
    always_comb begin
        phase_next = PhShow;
        if (32'(slot_cnt_d) < BLANK_CYCLES) begin
            phase_next = PhBlank;
        end
    end

    assign idx_next = idx_d;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes NUM_DIGITS signed digit values onto one shared segment decoder and
// drives the per-digit enables. Writes land in shadow registers; a commit copies them to
// the live set at the next frame end so a frame never shows a half-updated number.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   en            1: scanning runs; 0: digits off, scan position held
//   wr_en         write shadow[wr_digit] with {wr_sinal, wr_diff}
//   wr_digit      target digit (out-of-range indices ignored)
//   wr_diff       digit magnitude
//   wr_sinal      digit sign
//   commit        request shadow->active copy at next frame end
//   commit_pend   copy requested, not yet done
//   commit_done   1-cycle pulse after the copy
//   diff_out      magnitude of the digit being scanned
//   sinal_out     sign of the digit being scanned
//   digit_en      one-hot digit select, polarity set by DIGIT_ACTIVE_LOW
//   frame_tick    1-cycle pulse on the last cycle of each frame
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = DEFAULT_NUM_DIGITS,
    parameter int unsigned CLK_DIV          = 50000,
    parameter int unsigned BLANK_CYCLES     = 16,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [2:0]            wr_digit,
    input  logic [DIGIT_W-1:0]    wr_diff,
    input  logic                  wr_sinal,
    input  logic                  commit,
    output logic                  commit_pend,
    output logic                  commit_done,
    output logic [DIGIT_W-1:0]    diff_out,
    output logic                  sinal_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam int unsigned           IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{DIGIT_OFF ^ DIGIT_ACTIVE_LOW}};

    logic [IDX_W-1:0] idx_next;
    slot_phase_e      phase_next;

    digit_t                  shadow_q [NUM_DIGITS];
    digit_t                  shadow_d [NUM_DIGITS];
    digit_t                  active_q [NUM_DIGITS];
    digit_t                  active_d [NUM_DIGITS];
    logic                    commit_pend_q, commit_pend_d;
    logic                    commit_done_q, commit_done_d;
    digit_t                  cur_q, cur_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    do_copy;
    logic                    wr_ok;
    logic [IDX_W-1:0]        wr_idx;

    display_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .idx_next   (idx_next),
        .phase_next (phase_next),
        .frame_tick (frame_tick)
    );

    assign wr_ok   = (32'(wr_digit) < NUM_DIGITS);
    assign wr_idx  = wr_digit[IDX_W-1:0];
    assign do_copy = frame_tick & commit_pend_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en && wr_ok) begin
            shadow_d[wr_idx] = '{sinal: wr_sinal, diff: wr_diff};
        end
        // Copy from shadow_d so a write on the frame-end cycle is included.
        active_d = do_copy ? shadow_d : active_q;
        // A commit arriving on the copy cycle re-arms for the following frame end.
        commit_pend_d = commit | (commit_pend_q & ~do_copy);
        commit_done_d = do_copy;
        // Follows idx, which only moves at slot start (inside BLANK).
        cur_d = active_d[idx_next];
    end

    always_comb begin
        digit_en_d = ALL_OFF;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (en && phase_next == PhShow && idx_next == IDX_W'(i)) begin
                digit_en_d[i] = DIGIT_ON ^ DIGIT_ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            commit_pend_q <= 1'b0;
            commit_done_q <= 1'b0;
            cur_q         <= '0;
            digit_en_q    <= ALL_OFF;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
            commit_done_q <= commit_done_d;
            cur_q         <= cur_d;
            digit_en_q    <= digit_en_d;
        end
    end

    assign commit_pend = commit_pend_q;
    assign commit_done = commit_done_q;
    assign diff_out    = cur_q.diff;
    assign sinal_out   = cur_q.sinal;
    assign digit_en    = digit_en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: the stimulus process pushes expected values (tagged with the cycle
// they apply to) and expected pulse cycles; a negedge monitor pops and compares.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, wr_en, wr_sinal, commit;
    logic [2:0] wr_digit;
    logic [3:0] wr_diff;
    logic       commit_pend, commit_done, sinal_out, frame_tick;
    logic [3:0] diff_out, digit_en;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS       (4),
        .CLK_DIV          (8),
        .BLANK_CYCLES     (2),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_digit    (wr_digit),
        .wr_diff     (wr_diff),
        .wr_sinal    (wr_sinal),
        .commit      (commit),
        .commit_pend (commit_pend),
        .commit_done (commit_done),
        .diff_out    (diff_out),
        .sinal_out   (sinal_out),
        .digit_en    (digit_en),
        .frame_tick  (frame_tick)
    );

    typedef struct {
        int         cyc;
        string      name;
        int         kind;   // 0 digit_en, 1 diff_out, 2 sinal_out, 3 commit_pend
        logic [3:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         tick_q[$];
    int         done_q[$];
    int         cyc = 0;
    bit         started = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] mon_act;

    task automatic exp_en(input int c, input logic [3:0] v);
        exp_q.push_back('{c, "digit_en", 0, v});
    endtask

    task automatic exp_digit(input int c, input logic [3:0] d, input logic s);
        exp_q.push_back('{c, "diff_out", 1, d});
        exp_q.push_back('{c, "sinal_out", 2, {3'b000, s}});
    endtask

    task automatic exp_pend(input int c, input logic p);
        exp_q.push_back('{c, "commit_pend", 3, {3'b000, p}});
    endtask

    task automatic write(input logic [2:0] d, input logic [3:0] v, input logic s);
        wr_en    = 1'b1;
        wr_digit = d;
        wr_diff  = v;
        wr_sinal = s;
    endtask

    function automatic logic [3:0] actual(input int kind);
        case (kind)
            0:       return digit_en;
            1:       return diff_out;
            2:       return {3'b000, sinal_out};
            default: return {3'b000, commit_pend};
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (started) begin
            for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    mon_act = actual(exp_q[i].kind);
                    checks++;
                    if (mon_act !== exp_q[i].val) begin
                        failures++;
                        $display("FAIL %s cycle %0d: got %b expected %b", exp_q[i].name, cyc,
                                 mon_act, exp_q[i].val);
                    end
                    exp_q.delete(i);
                end
            end
            if (frame_tick !== 1'b0) begin
                checks++;
                if (tick_q.size() > 0 && tick_q[0] == cyc) begin
                    void'(tick_q.pop_front());
                end else begin
                    failures++;
                    $display("FAIL frame_tick cycle %0d: got %b expected 0", cyc, frame_tick);
                end
            end
            while (tick_q.size() > 0 && tick_q[0] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL frame_tick cycle %0d: got 0 expected 1", tick_q.pop_front());
            end
            if (commit_done !== 1'b0) begin
                checks++;
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    void'(done_q.pop_front());
                end else begin
                    failures++;
                    $display("FAIL commit_done cycle %0d: got %b expected 0", cyc, commit_done);
                end
            end
            while (done_q.size() > 0 && done_q[0] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL commit_done cycle %0d: got 0 expected 1", done_q.pop_front());
            end
        end
    end

    // Stimulus: inputs for cycle c are driven just after the edge that starts it.
    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        wr_en    = 1'b0;
        wr_digit = '0;
        wr_diff  = '0;
        wr_sinal = 1'b0;
        commit   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        for (int c = 0; c <= 325; c++) begin
            cyc    = c;
            wr_en  = 1'b0;
            commit = 1'b0;
            en     = !(c >= 204 && c <= 223);
            rst_n  = !(c >= 285 && c <= 287);
            case (c)
                0: begin
                    exp_en(0, 4'b1111);
                    exp_digit(0, 4'd0, 1'b0);
                    exp_pend(0, 1'b0);
                    exp_en(1, 4'b1111);
                    exp_en(2, 4'b1110);
                    exp_en(7, 4'b1110);
                    exp_en(8, 4'b1111);
                    exp_en(10, 4'b1101);
                    exp_en(26, 4'b0111);
                    tick_q.push_back(31);
                    tick_q.push_back(63);
                    tick_q.push_back(95);
                end
                1: write(3'd0, 4'd3, 1'b0);
                2: begin
                    write(3'd1, 4'd5, 1'b1);
                    // No commit yet: live digits stay zero.
                    exp_digit(34, 4'd0, 1'b0);
                    exp_digit(42, 4'd0, 1'b0);
                    exp_digit(66, 4'd0, 1'b0);
                    exp_digit(74, 4'd0, 1'b0);
                end
                100: begin
                    commit = 1'b1;
                    exp_pend(101, 1'b1);
                    exp_pend(127, 1'b1);
                    exp_pend(128, 1'b0);
                    tick_q.push_back(127);
                    tick_q.push_back(159);
                    done_q.push_back(128);
                    exp_digit(127, 4'd0, 1'b0);
                    exp_digit(128, 4'd3, 1'b0);
                    exp_digit(136, 4'd5, 1'b1);
                    exp_digit(144, 4'd0, 1'b0);
                end
                159: begin
                    // Commit on the frame-end cycle waits a full frame.
                    write(3'd2, 4'd9, 1'b0);
                    commit = 1'b1;
                    exp_pend(160, 1'b1);
                    exp_pend(191, 1'b1);
                    exp_pend(192, 1'b0);
                    tick_q.push_back(191);
                    done_q.push_back(192);
                    exp_digit(178, 4'd0, 1'b0);
                end
                204: begin
                    exp_en(204, 4'b1101);
                    exp_en(205, 4'b1111);
                    exp_en(224, 4'b1111);
                    exp_en(225, 4'b1101);
                    exp_en(228, 4'b1111);
                    exp_en(230, 4'b1011);
                    exp_digit(215, 4'd5, 1'b1);
                    tick_q.push_back(243);
                end
                210: write(3'd3, 4'd4, 1'b0);
                215: write(3'd5, 4'd7, 1'b0);
                230: begin
                    commit = 1'b1;
                    exp_digit(230, 4'd9, 1'b0);
                    exp_pend(231, 1'b1);
                    exp_pend(244, 1'b0);
                    done_q.push_back(244);
                    tick_q.push_back(275);
                    exp_digit(254, 4'd5, 1'b1);
                    exp_digit(270, 4'd4, 1'b0);
                end
                280: begin
                    commit = 1'b1;
                    exp_pend(281, 1'b1);
                end
                285: begin
                    exp_pend(286, 1'b0);
                    exp_en(286, 4'b1111);
                    exp_digit(286, 4'd0, 1'b0);
                    exp_en(287, 4'b1111);
                end
                288: begin
                    exp_digit(288, 4'd0, 1'b0);
                    exp_en(290, 4'b1110);
                    exp_digit(290, 4'd0, 1'b0);
                    exp_pend(290, 1'b0);
                    exp_en(300, 4'b1101);
                    tick_q.push_back(319);
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        cyc = 326;
        @(negedge clk);
        foreach (exp_q[i]) begin
            checks++;
            failures++;
            $display("FAIL %s cycle %0d: got unchecked expected %b", exp_q[i].name, exp_q[i].cyc,
                     exp_q[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
